// File: rtl/core_sweep_controller.sv
// Per-tick neuron sweep sequencer sitting in front of core_sram.
// Each row is read, passed through the neuron datapath and written back in place.
module core_sweep_controller #(
    parameter int NUM_NEURONS = 256,
    parameter int ADDR_W      = 8,
    parameter int ROW_W       = 410,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    output logic              sram_read_request,
    output logic              sram_write_request,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [ROW_W-1:0]  sram_write_data,
    input  logic [ROW_W-1:0]  sram_read_data,
    input  logic              sram_ready,
    input  logic              sram_error,
    output logic              nrn_row_valid,
    input  logic              nrn_row_ready,
    output logic [ADDR_W-1:0] nrn_row_addr,
    output logic [ROW_W-1:0]  nrn_row_data,
    input  logic              nrn_upd_valid,
    output logic              nrn_upd_ready,
    input  logic [ROW_W-1:0]  nrn_upd_data,
    output logic              busy,
    output logic              sweep_done,
    output logic              tick_overrun,
    output logic              fault,
    output logic [1:0]        fault_code
);

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        PRESENT,
        COLLECT,
        WR_REQ,
        WR_WAIT,
        NEXT,
        FAULT
    } state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_ERR  = 2'b01;
    localparam logic [1:0] FC_TMO  = 2'b10;

    // One spare bit so a full 2**ADDR_W sweep can still detect its last row.
    localparam logic [ADDR_W:0] LAST_ROW = (ADDR_W + 1)'(NUM_NEURONS - 1);
    localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   row;
    logic [ADDR_W:0]   row_next;
    logic [ROW_W-1:0]  rd_buf;
    logic [ROW_W-1:0]  wr_buf;
    logic [1:0]        code;
    logic [1:0]        code_next;
    logic [7:0]        tmo_cnt;
    logic              waiting;
    logic              active;
    logic              tmo_hit;
    logic              last_row;
    logic              rd_load;
    logic              wr_load;

    assign last_row = (row == LAST_ROW);
    assign waiting  = state inside {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT};
    assign active   = (state != IDLE) && (state != FAULT);
    assign tmo_hit  = waiting && !sram_ready && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            rd_buf  <= '0;
            wr_buf  <= '0;
            code    <= FC_NONE;
            tmo_cnt <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
            code  <= code_next;
            if (rd_load) begin
                rd_buf <= sram_read_data;
            end
            if (wr_load) begin
                wr_buf <= nrn_upd_data;
            end
            // Restart on every state change so each wait phase gets its own budget.
            if (!waiting || (state_next != state)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_next         = state;
        row_next           = row;
        code_next          = code;
        rd_load            = 1'b0;
        wr_load            = 1'b0;
        sram_read_request  = 1'b0;
        sram_write_request = 1'b0;
        nrn_row_valid      = 1'b0;
        nrn_upd_ready      = 1'b0;
        busy               = 1'b0;
        sweep_done         = 1'b0;
        tick_overrun       = 1'b0;

        unique case (state)
            IDLE: begin
                if (tick) begin
                    row_next   = '0;
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                busy = 1'b1;
                if (sram_ready) begin
                    sram_read_request = 1'b1;
                    state_next        = RD_WAIT;
                end
            end
            RD_WAIT: begin
                busy = 1'b1;
                if (sram_ready) begin
                    rd_load    = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                busy          = 1'b1;
                nrn_row_valid = 1'b1;
                if (nrn_row_ready) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                busy          = 1'b1;
                nrn_upd_ready = 1'b1;
                if (nrn_upd_valid) begin
                    wr_load    = 1'b1;
                    state_next = WR_REQ;
                end
            end
            WR_REQ: begin
                busy = 1'b1;
                if (sram_ready) begin
                    sram_write_request = 1'b1;
                    state_next         = WR_WAIT;
                end
            end
            WR_WAIT: begin
                busy = 1'b1;
                if (sram_ready) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (last_row) begin
                    sweep_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    busy       = 1'b1;
                    row_next   = row + 1'b1;
                    state_next = RD_REQ;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (active) begin
            tick_overrun = tick;
            // A reported SRAM error outranks a timeout hitting in the same cycle.
            if (sram_error || tmo_hit) begin
                state_next         = FAULT;
                code_next          = sram_error ? FC_ERR : FC_TMO;
                row_next           = row;
                rd_load            = 1'b0;
                wr_load            = 1'b0;
                sram_read_request  = 1'b0;
                sram_write_request = 1'b0;
                sweep_done         = 1'b0;
            end
        end
    end

    assign sram_addr       = row[ADDR_W-1:0];
    assign nrn_row_addr    = row[ADDR_W-1:0];
    assign nrn_row_data    = rd_buf;
    assign sram_write_data = wr_buf;
    assign fault           = (state == FAULT);
    assign fault_code      = code;

endmodule
